// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
//
// Shared definitions for the sequential shift-and-add multiplier.
//
// Contents:
//   mul_state_t   - control state of the multiplier (IDLE, BUSY, DONE)
//   MAG_MAX_WIDTH - widest operand the magnitude helper can handle
//   twos_mag()    - magnitude of a two's-complement value of a given width,
//                   or the raw value when the operation is unsigned
//   cfg_ok()      - legality check for the WIDTH / BITS_PER_CYCLE pair,
//                   used by the top to raise an elaboration error
// ---------------------------------------------------------------------------
package mul_pkg;

  // Control states of the multiplier.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Operands are zero-extended to this width before the magnitude helper
  // runs, so one function serves every legal WIDTH.
  localparam int MAG_MAX_WIDTH = 128;

  // Returns |value| for a signed operand of 'width' bits, or the raw value
  // for an unsigned one. Only the low 'width' bits of the result are
  // meaningful; the rest are zero. The most negative number maps to
  // 2^(width-1), which still fits in 'width' unsigned bits.
  function automatic logic [MAG_MAX_WIDTH-1:0] twos_mag(
    input logic [MAG_MAX_WIDTH-1:0] value,
    input int                       width,
    input logic                     is_signed
  );
    logic [MAG_MAX_WIDTH-1:0] mask;
    logic [MAG_MAX_WIDTH-1:0] neg;
    logic                     top_bit;
    mask    = (MAG_MAX_WIDTH'(1) << width) - MAG_MAX_WIDTH'(1);
    top_bit = |(value & (MAG_MAX_WIDTH'(1) << (width - 1)));
    neg     = (~value + MAG_MAX_WIDTH'(1)) & mask;
    if (is_signed && top_bit) begin
      return neg;
    end
    return value & mask;
  endfunction

  // A configuration is legal when the operand is at least two bits wide,
  // fits the magnitude helper, and splits into whole steps.
  function automatic bit cfg_ok(input int width, input int bpc);
    return (width >= 2) && (width <= MAG_MAX_WIDTH) &&
           (bpc >= 1) && (bpc <= width) && ((width % bpc) == 0);
  endfunction

endpackage

// File: rtl/mul_step.sv
// ---------------------------------------------------------------------------
// mul_step
//
// One iteration of the shift-and-add multiplier (purely combinational).
// Forms the partial product of BITS_PER_CYCLE multiplier bits with the
// multiplicand, shifts it into place for the current step and adds it to
// the running accumulator.
//
// Ports:
//   acc_i    in  2*WIDTH         running accumulator
//   mcand_i  in  WIDTH           multiplicand magnitude
//   bits_i   in  BITS_PER_CYCLE  multiplier bits retired this step
//   count_i  in  CNT_W           step index (0 .. N-1)
//   acc_o    out 2*WIDTH         accumulator after this step
// ---------------------------------------------------------------------------
module mul_step
  import mul_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int CNT_W          = 5
) (
  input  logic [2*WIDTH-1:0]        acc_i,
  input  logic [WIDTH-1:0]          mcand_i,
  input  logic [BITS_PER_CYCLE-1:0] bits_i,
  input  logic [CNT_W-1:0]          count_i,
  output logic [2*WIDTH-1:0]        acc_o
);

  localparam int ACC_W = 2 * WIDTH;
  localparam int SH_W  = $clog2(ACC_W) + 1;

  logic [ACC_W-1:0] partial;
  logic [ACC_W-1:0] shifted;
  logic [SH_W-1:0]  shamt;

  // Shift-and-add over the retired bits, then align the partial product
  // to the bit position of this step. The full product of two WIDTH-bit
  // magnitudes fits in 2*WIDTH bits, so the sum never carries out.
  always_comb begin
    partial = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (bits_i[k]) begin
        partial = partial + (ACC_W'(mcand_i) << k);
      end
    end
    shamt   = SH_W'(count_i) * SH_W'(BITS_PER_CYCLE);
    shifted = partial << shamt;
    acc_o   = acc_i + shifted;
  end

endmodule

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//
// Iterative shift-and-add multiplier with valid/ready handshakes on both
// sides. Operands are converted to magnitudes on accept, multiplied over
// N = WIDTH/BITS_PER_CYCLE busy cycles, and the sign is applied to the
// 2*WIDTH result on the last step. The product is held in DONE until the
// consumer takes it.
//
// Ports:
//   clk        in  1        clock, rising edge
//   rst        in  1        synchronous active-high reset
//   in_valid   in  1        operands and mode are valid
//   in_ready   out 1        unit can accept an operation (IDLE)
//   a          in  WIDTH    multiplicand
//   b          in  WIDTH    multiplier
//   is_signed  in  1        1: two's-complement operation, 0: unsigned
//   out_valid  out 1        product is valid (DONE)
//   out_ready  in  1        consumer accepts the product
//   product    out 2*WIDTH  full product
//   busy       out 1        an operation is in flight (BUSY)
// ---------------------------------------------------------------------------
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
  localparam bit CFG_OK = cfg_ok(WIDTH, BITS_PER_CYCLE);

  // Illegal parameter combinations stop elaboration.
  if (!CFG_OK) begin : g_cfg_check
    $error("seq_multiplier: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
  end

  mul_state_t           state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mult_q, mult_d;
  logic                 sign_q, sign_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [2*WIDTH-1:0]   step_acc;

  // One shift-and-add iteration on the current registers.
  mul_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .CNT_W          (CNT_W)
  ) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .bits_i  (mult_q[BITS_PER_CYCLE-1:0]),
    .count_i (count_q),
    .acc_o   (step_acc)
  );

  // State and datapath registers; reset clears everything, discarding any
  // operation in flight and any product waiting to be drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mult_q    <= '0;
      sign_q    <= 1'b0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mult_q    <= mult_d;
      sign_q    <= sign_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // Next-state and datapath control. Operands presented outside IDLE are
  // ignored because only the IDLE branch looks at in_valid.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mult_d    = mult_q;
    sign_d    = sign_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = WIDTH'(twos_mag(MAG_MAX_WIDTH'(a), WIDTH, is_signed));
          mult_d  = WIDTH'(twos_mag(MAG_MAX_WIDTH'(b), WIDTH, is_signed));
          sign_d  = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d   = '0;
          count_d = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        acc_d   = step_acc;
        mult_d  = mult_q >> BITS_PER_CYCLE;
        count_d = count_q + CNT_W'(1);
        // Last step: apply the sign to the finished magnitude. Negating
        // zero yields zero, so a zero product never comes out as -0.
        if (count_q == LAST_STEP) begin
          product_d = sign_q ? (~step_acc + 1'b1) : step_acc;
          state_d   = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign product   = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
//
// Drives two multipliers side by side from the same inputs: WIDTH=32 with
// one bit per cycle (32-cycle latency) and four bits per cycle (8-cycle
// latency). Directed vectors carry hand-computed products; a short random
// run uses a reference product computed in the bench.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          is_signed;
  logic          out_ready;

  logic          in_ready1, out_valid1, busy1;
  logic [2*W-1:0] product1;
  logic          in_ready4, out_valid4, busy4;
  logic [2*W-1:0] product4;

  int checks = 0;
  int errors = 0;
  int cycle_count = 0;
  int accept_cycle = 0;

  seq_multiplier #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .product   (product1),
    .busy      (busy1)
  );

  seq_multiplier #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .product   (product4),
    .busy      (busy4)
  );

  // Free-running clock and a cycle counter used to measure accept spacing.
  always #5 clk = ~clk;

  always @(posedge clk) cycle_count <= cycle_count + 1;

  // Hard stop in case a handshake never completes.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] refProduct(input logic [31:0] x,
                                             input logic [31:0] y,
                                             input logic s);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return sx * sy;
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Called at a negedge with both units idle; accept happens on the next
  // posedge and the task returns at the negedge just after it.
  task automatic applyStimulus(input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                               input logic s_in);
    a         = a_in;
    b         = b_in;
    is_signed = s_in;
    in_valid  = 1'b1;
    checkOutput("ready_before_accept", {62'b0, in_ready1, in_ready4}, 64'd3);
    @(negedge clk);
    in_valid     = 1'b0;
    accept_cycle = cycle_count;
    checkOutput("busy_after_accept", {60'b0, busy1, busy4, in_ready1, in_ready4},
                64'b1100);
  endtask

  // Watches both units after accept, recording the first cycle each shows
  // out_valid and the product it presents. Returns at the negedge where
  // the 1-bit unit first shows out_valid (or after the cycle budget).
  task automatic waitResult(input string tag, input logic [63:0] expected);
    int lat1 = -1;
    int lat4 = -1;
    logic [63:0] p1 = '0;
    logic [63:0] p4 = '0;
    for (int k = 0; k <= 40 && lat1 < 0; k++) begin
      if (out_valid4 && lat4 < 0) begin
        lat4 = k;
        p4   = product4;
      end
      if (out_valid1 && lat1 < 0) begin
        lat1 = k;
        p1   = product1;
      end
      if (lat1 < 0) @(negedge clk);
    end
    checkOutput({tag, "_lat_bpc1"}, 64'(lat1), 64'd32);
    checkOutput({tag, "_lat_bpc4"}, 64'(lat4), 64'd8);
    checkOutput({tag, "_prod_bpc1"}, p1, expected);
    checkOutput({tag, "_prod_bpc4"}, p4, expected);
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] a_in,
                       input logic [W-1:0] b_in, input logic s_in,
                       input logic [63:0] expected);
    applyStimulus(a_in, b_in, s_in);
    waitResult(tag, expected);
    @(negedge clk);
  endtask

  initial begin
    int first_accept;
    int stray_valid;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    is_signed = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state.
    checkOutput("reset_ctrl_bpc1", {61'b0, in_ready1, out_valid1, busy1}, 64'b100);
    checkOutput("reset_ctrl_bpc4", {61'b0, in_ready4, out_valid4, busy4}, 64'b100);
    checkOutput("reset_prod_bpc1", product1, 64'd0);
    checkOutput("reset_prod_bpc4", product4, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors.
    runOp("u_max_x_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    runOp("s_m3_x_7",    32'hFFFF_FFFD, 32'd7,         1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    runOp("u_fffd_x_7",  32'hFFFF_FFFD, 32'd7,         1'b0, 64'h0000_0006_FFFF_FFEB);
    runOp("s_min_x_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    runOp("s_min_x_1",   32'h8000_0000, 32'd1,         1'b1, 64'hFFFF_FFFF_8000_0000);
    runOp("u_1234_9abc", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'h0B00_EA4E_242D_2080);
    runOp("u_zero",      32'd0,         32'h1234,      1'b0, 64'd0);
    runOp("s_zero_neg",  32'd0,         32'hFFFF_FFF0, 1'b1, 64'd0);
    runOp("s_1_x_m1",    32'd1,         32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    runOp("s_m1_x_m1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1);

    // Back-to-back with out_ready held high: accepts N+2 cycles apart.
    runOp("b2b_first", 32'd100, 32'd200, 1'b0, 64'd20000);
    first_accept = accept_cycle;
    runOp("b2b_second", 32'd3, 32'hFFFF_FFFB, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    checkOutput("b2b_spacing", 64'(accept_cycle - first_accept), 64'd34);

    // Backpressure: hold the product for 10 cycles while new requests
    // arrive, then release and accept on the edge right after the drain.
    out_ready = 1'b0;
    applyStimulus(32'h0001_0001, 32'h0002_0003, 1'b0);
    waitResult("bp", 64'h0000_0002_0005_0003);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a        = 32'd5;
      b        = 32'd5;
      @(negedge clk);
      checkOutput("bp_hold_ctrl", {61'b0, out_valid1, in_ready1, busy1}, 64'b100);
      checkOutput("bp_hold_prod1", product1, 64'h0000_0002_0005_0003);
      checkOutput("bp_hold_prod4", product4, 64'h0000_0002_0005_0003);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_drained", {60'b0, out_valid1, in_ready1, out_valid4, in_ready4},
                64'b0101);
    applyStimulus(32'd9, 32'd11, 1'b0);
    waitResult("bp_next", 64'd99);
    @(negedge clk);

    // Reset in the middle of BUSY, with a simultaneous request.
    applyStimulus(32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
    repeat (5) @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 32'd3;
    b        = 32'd3;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    checkOutput("midrst_ctrl_bpc1", {61'b0, in_ready1, out_valid1, busy1}, 64'b100);
    checkOutput("midrst_ctrl_bpc4", {61'b0, in_ready4, out_valid4, busy4}, 64'b100);
    checkOutput("midrst_prod_bpc1", product1, 64'd0);
    checkOutput("midrst_prod_bpc4", product4, 64'd0);
    stray_valid = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid1 || out_valid4 || busy1 || busy4) stray_valid++;
      @(negedge clk);
    end
    checkOutput("midrst_no_valid", 64'(stray_valid), 64'd0);
    runOp("post_reset_6x7", 32'd6, 32'd7, 1'b0, 64'd42);

    // Random pairs in both modes against the bench reference product.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      runOp("rand", ra, rb, 1'(i % 2), refProduct(ra, rb, 1'(i % 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
